// File: rtl/seq_fetch_if.sv
// seq_fetch_if: link between the fetch controller and the Seq sequencer.
//
//   inst      fetch -> Seq   instruction word, valid only while inst_wen is high
//   inst_wen  fetch -> Seq   one-cycle instruction write strobe
//   seq_next  Seq -> fetch   Seq's next-address output, sampled in WAIT
//
// Modports: master = fetch controller side, slave = sequencer side.
interface seq_fetch_if #(
    parameter int InstSize = 12,
    parameter int AddrSize = 8
);
    logic [InstSize-1:0] inst;
    logic                inst_wen;
    logic [AddrSize-1:0] seq_next;

    modport master (output inst, output inst_wen, input seq_next);
    modport slave  (input inst, input inst_wen, output seq_next);
endinterface

// File: rtl/seq_fetch.sv
// seq_fetch: instruction fetch controller for the Seq sequencer.
//
// Holds a 2^AddrSize x InstSize program memory. The host loads it while the
// unit is stopped (IDLE or DONE). On start the unit issues instructions one
// at a time (FETCH -> ISSUE -> WAIT) starting at address 0. It follows Seq's
// next-address output as its program counter, and stops in DONE when Seq
// points back at the instruction just issued.
//
// Ports:
//   clock, reset          clock and asynchronous active-high reset
//   prog_addr/data/wen    program memory write port (honoured only when stopped)
//   start                 begin execution at address 0 (ignored while running)
//   halt                  abort execution; has priority over start
//   seq_bus (master)      inst / inst_wen to Seq, seq_next from Seq
//   pc                    address of the current or most recent instruction
//   running               high in FETCH, ISSUE and WAIT
//   done                  high in DONE
//   issued                instructions issued since the last start (saturating)
//   prog_err              sticky flag: a program write arrived while running
module seq_fetch #(
    parameter int InstSize = 12,
    parameter int AddrSize = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [AddrSize-1:0] prog_addr,
    input  logic [InstSize-1:0] prog_data,
    input  logic                prog_wen,
    input  logic                start,
    input  logic                halt,
    seq_fetch_if.master         seq_bus,
    output logic [AddrSize-1:0] pc,
    output logic                running,
    output logic                done,
    output logic [15:0]         issued,
    output logic                prog_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int Depth = 1 << AddrSize;

    logic [InstSize-1:0] mem [Depth];

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       stopped;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign stopped = (state == S_IDLE) || (state == S_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start && !halt)
                    state_nxt = S_FETCH;
            end
            S_FETCH: state_nxt = halt ? S_IDLE : S_ISSUE;
            S_ISSUE: state_nxt = halt ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (halt)
                    state_nxt = S_IDLE;
                else if (seq_bus.seq_next == pc)
                    state_nxt = S_DONE;
                else
                    state_nxt = S_FETCH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Program memory is not reset. Writes land only while stopped, so a
    // write coinciding with start is visible to the FETCH that follows.
    always_ff @(posedge clock) begin
        if (prog_wen && stopped)
            mem[prog_addr] <= prog_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            seq_bus.inst     <= '0;
            seq_bus.inst_wen <= 1'b0;
            pc               <= '0;
            running          <= 1'b0;
            done             <= 1'b0;
            issued           <= '0;
            prog_err         <= 1'b0;
        end else begin
            state <= state_nxt;
            // Status flags follow the next state so they are registered
            // outputs that line up with the state they describe.
            running <= (state_nxt == S_FETCH) || (state_nxt == S_ISSUE) ||
                       (state_nxt == S_WAIT);
            done    <= (state_nxt == S_DONE);

            if (prog_wen && !stopped)
                prog_err <= 1'b1;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start && !halt) begin
                        pc     <= '0;
                        issued <= '0;
                    end
                end
                S_FETCH: begin
                    // A halt here aborts before the strobe is raised.
                    if (!halt) begin
                        seq_bus.inst     <= mem[pc];
                        seq_bus.inst_wen <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    // The strobe is already high this cycle, so the
                    // instruction counts even if halt is also asserted.
                    seq_bus.inst_wen <= 1'b0;
                    issued           <= sat_inc(issued);
                end
                S_WAIT: begin
                    if (!halt && (seq_bus.seq_next != pc))
                        pc <= seq_bus.seq_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_fetch.sv
module tb_seq_fetch;

    logic        clock;
    logic        reset;
    logic [7:0]  prog_addr;
    logic [11:0] prog_data;
    logic        prog_wen;
    logic        start;
    logic        halt;
    logic [7:0]  pc;
    logic        running;
    logic        done;
    logic [15:0] issued;
    logic        prog_err;

    seq_fetch_if #(.InstSize(12), .AddrSize(8)) bus ();

    seq_fetch #(.InstSize(12), .AddrSize(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_wen  (prog_wen),
        .start     (start),
        .halt      (halt),
        .seq_bus   (bus),
        .pc        (pc),
        .running   (running),
        .done      (done),
        .issued    (issued),
        .prog_err  (prog_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Seq model: next address is a lookup on the issuing address.
    logic [7:0] next_tbl [256];
    logic [7:0] seq_model_next;
    always_comb seq_model_next = next_tbl[pc];
    assign bus.seq_next = seq_model_next;

    // Reference program image and expected issue stream.
    logic [11:0] model_mem [256];
    logic [11:0] exp_inst [$];
    logic [7:0]  exp_pc   [$];

    typedef struct {
        logic [11:0] inst;
        logic [7:0]  pc;
        int          cyc;
    } pulse_t;
    pulse_t pulses [$];
    pulse_t mon_p;

    always @(negedge clock) begin
        if (bus.inst_wen === 1'b1) begin
            mon_p.inst = bus.inst;
            mon_p.pc   = pc;
            mon_p.cyc  = cyc;
            pulses.push_back(mon_p);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic load(input logic [7:0] a, input logic [11:0] d);
        prog_addr = a;
        prog_data = d;
        prog_wen  = 1'b1;
        tick();
        prog_wen  = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic clear_next();
        for (int i = 0; i < 256; i++) next_tbl[i] = i[7:0];
    endtask

    // Expected stream: start at 0, issue mem[pc], stop when next == pc.
    task automatic model_run();
        logic [7:0] p;
        exp_inst.delete();
        exp_pc.delete();
        p = 8'd0;
        for (int k = 0; k < 300; k++) begin
            exp_inst.push_back(model_mem[p]);
            exp_pc.push_back(p);
            if (next_tbl[p] == p) break;
            p = next_tbl[p];
        end
    endtask

    // Index of the first pulse diverging from the expected stream
    // (content, address, or 2 + 3k cycle spacing from start), or -1.
    function automatic int pulse_diff(input int sc, input int n);
        for (int i = 0; i < n; i++) begin
            if (i >= pulses.size()) return i;
            if (pulses[i].inst !== exp_inst[i] || pulses[i].pc !== exp_pc[i] ||
                pulses[i].cyc != sc + 2 + 3 * i)
                return i;
        end
        if (pulses.size() != n) return n;
        return -1;
    endfunction

    function automatic string describe(input int i, input int sc);
        string s;
        s = $sformatf("at pulse %0d of %0d got", i, pulses.size());
        if (i < pulses.size())
            s = {s, $sformatf(" inst=%h pc=%0d cyc=%0d", pulses[i].inst, pulses[i].pc, pulses[i].cyc)};
        else
            s = {s, " none"};
        if (i < exp_inst.size())
            s = {s, $sformatf(" required inst=%h pc=%0d cyc=%0d", exp_inst[i], exp_pc[i], sc + 2 + 3 * i)};
        else
            s = {s, " required no pulse"};
        return s;
    endfunction

    task automatic start_run(output int sc);
        pulses.delete();
        sc    = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (done !== 1'b1 && t < 2000) begin
            tick();
            t++;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, done, t);
        end
    endtask

    task automatic setup_line();
        clear_next();
        load(8'd0, 12'h101);
        load(8'd1, 12'h202);
        load(8'd2, 12'h303);
        load(8'd3, 12'h404);
        next_tbl[0] = 8'd1;
        next_tbl[1] = 8'd2;
        next_tbl[2] = 8'd3;
        next_tbl[3] = 8'd3;
    endtask

    task automatic test_reset();
        logic [35:0] got;
        reset     = 1'b1;
        start     = 1'b0;
        halt      = 1'b0;
        prog_wen  = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        clear_next();
        ticks(3);
        reset = 1'b0;
        pulses.delete();
        tick();
        got = {bus.inst, bus.inst_wen, pc, running, done, issued, prog_err};
        n_checks++;
        if (got !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", got);
        end
        ticks(50);
        n_checks++;
        if (pulses.size() != 0) begin
            n_fail++;
            $display("FAIL reset_idle_pulses: got %0d pulses required 0", pulses.size());
        end
    endtask

    task automatic test_straight_line();
        int sc, d;
        setup_line();
        start_run(sc);
        wait_done("line");
        model_run();
        d = pulse_diff(sc, exp_inst.size());
        n_checks++;
        if (d !== -1) begin
            n_fail++;
            $display("FAIL line_stream: %s", describe(d, sc));
        end
        n_checks++;
        if ({done, pc, issued} !== {1'b1, 8'd3, 16'd4}) begin
            n_fail++;
            $display("FAIL line_final: done=%b pc=%0d issued=%0d required 1 3 4", done, pc, issued);
        end
    endtask

    task automatic test_jump_wrap();
        int sc, d, t;
        clear_next();
        load(8'd0, 12'h0A5);
        load(8'd255, 12'h5A0);
        next_tbl[0]   = 8'd255;
        next_tbl[255] = 8'd0;
        start_run(sc);
        t = 0;
        while (pulses.size() < 5 && t < 200) begin
            tick();
            t++;
        end
        halt = 1'b1;
        tick();
        halt = 1'b0;
        model_run();
        d = pulse_diff(sc, 5);
        n_checks++;
        if (d !== -1) begin
            n_fail++;
            $display("FAIL wrap_stream: %s", describe(d, sc));
        end
        ticks(10);
        n_checks++;
        if ({running, done, issued} !== {1'b0, 1'b0, 16'd5} || pulses.size() != 5) begin
            n_fail++;
            $display("FAIL wrap_halt: running=%b done=%b issued=%0d pulses=%0d required 0 0 5 5",
                     running, done, issued, pulses.size());
        end
    endtask

    task automatic test_halt_issue();
        int sc, seen, t;
        setup_line();
        start_run(sc);
        seen = 0;
        t = 0;
        while (seen < 2 && t < 100) begin
            if (bus.inst_wen === 1'b1) seen++;
            if (seen < 2) tick();
            t++;
        end
        halt = 1'b1;
        tick();
        halt = 1'b0;
        n_checks++;
        if ({running, done, issued} !== {1'b0, 1'b0, 16'd2}) begin
            n_fail++;
            $display("FAIL halt_issue_state: running=%b done=%b issued=%0d required 0 0 2",
                     running, done, issued);
        end
        ticks(20);
        n_checks++;
        if (pulses.size() != 2) begin
            n_fail++;
            $display("FAIL halt_issue_pulses: got %0d required 2", pulses.size());
        end
    endtask

    task automatic test_write_running();
        int sc, d;
        setup_line();
        start_run(sc);
        ticks(3);
        prog_addr = 8'd2;
        prog_data = 12'hFFF;
        prog_wen  = 1'b1;
        tick();
        prog_wen  = 1'b0;
        n_checks++;
        if (prog_err !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_run_err: got %b required 1", prog_err);
        end
        wait_done("wr_run_first");
        start_run(sc);
        wait_done("wr_run_rerun");
        model_run();
        d = pulse_diff(sc, exp_inst.size());
        n_checks++;
        if (d !== -1) begin
            n_fail++;
            $display("FAIL wr_run_rerun_stream: %s", describe(d, sc));
        end
        // Reset to reach IDLE; memory contents must survive it.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (prog_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_run_err_clear: got %b required 0", prog_err);
        end
        pulses.delete();
        sc        = cyc;
        prog_addr = 8'd0;
        prog_data = 12'hABC;
        prog_wen  = 1'b1;
        start     = 1'b1;
        tick();
        prog_wen  = 1'b0;
        start     = 1'b0;
        model_mem[0] = 12'hABC;
        wait_done("same_cycle");
        n_checks++;
        if (pulses.size() == 0 || pulses[0].inst !== 12'hABC) begin
            n_fail++;
            $display("FAIL same_cycle_first: got %h required abc",
                     pulses.size() ? pulses[0].inst : 12'hxxx);
        end
        model_run();
        d = pulse_diff(sc, exp_inst.size());
        n_checks++;
        if (d !== -1) begin
            n_fail++;
            $display("FAIL same_cycle_stream: %s", describe(d, sc));
        end
    endtask

    task automatic test_collision_done();
        int sc, d;
        logic [15:0] issued_after_start;
        // Entered from DONE left by the previous run (4 instructions).
        model_run();
        pulses.delete();
        start = 1'b1;
        halt  = 1'b1;
        tick();
        start = 1'b0;
        halt  = 1'b0;
        ticks(5);
        n_checks++;
        if ({done, running, issued} !== {1'b1, 1'b0, 16'(exp_inst.size())} || pulses.size() != 0) begin
            n_fail++;
            $display("FAIL collide_done: done=%b running=%b issued=%0d pulses=%0d required 1 0 %0d 0",
                     done, running, issued, pulses.size(), exp_inst.size());
        end
        start_run(sc);
        issued_after_start = issued;
        n_checks++;
        if ({issued_after_start, pc, running} !== {16'd0, 8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL collide_restart: issued=%0d pc=%0d running=%b required 0 0 1",
                     issued_after_start, pc, running);
        end
        wait_done("collide_rerun");
        d = pulse_diff(sc, exp_inst.size());
        n_checks++;
        if (d !== -1) begin
            n_fail++;
            $display("FAIL collide_stream: %s", describe(d, sc));
        end
    endtask

    task automatic test_random();
        int sc, d, len;
        logic [7:0] a;
        logic [7:0] addrs [$];
        logic used [256];
        for (int it = 0; it < 4; it++) begin
            clear_next();
            for (int i = 0; i < 256; i++) used[i] = 1'b0;
            addrs.delete();
            len = $urandom_range(1, 12);
            addrs.push_back(8'd0);
            used[0] = 1'b1;
            for (int k = 1; k < len; k++) begin
                do a = 8'($urandom_range(0, 255)); while (used[a]);
                used[a] = 1'b1;
                addrs.push_back(a);
            end
            for (int k = 0; k < len; k++) begin
                load(addrs[k], 12'($urandom));
                next_tbl[addrs[k]] = (k == len - 1) ? addrs[k] : addrs[k + 1];
            end
            start_run(sc);
            wait_done($sformatf("rand%0d", it));
            model_run();
            d = pulse_diff(sc, exp_inst.size());
            n_checks++;
            if (d !== -1) begin
                n_fail++;
                $display("FAIL rand%0d_stream: %s", it, describe(d, sc));
            end
            n_checks++;
            if ({pc, issued} !== {addrs[len - 1], 16'(len)}) begin
                n_fail++;
                $display("FAIL rand%0d_final: pc=%0d issued=%0d required %0d %0d",
                         it, pc, issued, addrs[len - 1], len);
            end
        end
    endtask

    task automatic test_reset_mid();
        int sc;
        logic [35:0] got;
        setup_line();
        start_run(sc);
        ticks(4);
        #2;
        reset = 1'b1;
        #1;
        got = {bus.inst, bus.inst_wen, pc, running, done, issued, prog_err};
        n_checks++;
        if (got !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %h required 0", got);
        end
        ticks(2);
        reset = 1'b0;
        pulses.delete();
        ticks(30);
        n_checks++;
        if (pulses.size() != 0 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: pulses=%0d running=%b required 0 0", pulses.size(), running);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        test_reset();
        test_straight_line();
        test_jump_wrap();
        test_halt_issue();
        test_write_running();
        test_collision_done();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
